// File: rtl/frame_buffer_arbiter.sv
// Arbitrates a single-port frame buffer RAM between one-shot camera capture
// and a readout requester; reads are only served while no capture is active.
module frame_buffer_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 160000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_req,
  input  logic              fv,
  input  logic              cam_wr_en,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        state,
  output logic              capture_done,
  output logic              overflow_err,
  output logic [ADDR_W-1:0] pixel_count
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READY   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                fv_q;
  logic                capture_done_q;
  logic                overflow_q;
  logic [ADDR_W-1:0]   pixel_count_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                rd_p1_q, rd_p2_q, rd_oor1_q, rd_oor2_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic fv_rise, fv_fall, wr_accept, wr_in_range, rd_in_range, enter_capture;

  assign fv_rise       = fv & ~fv_q;
  assign fv_fall       = ~fv & fv_q;
  assign wr_accept     = (state_q == CAPTURE) && cam_wr_en;
  assign wr_in_range   = cam_addr < DEPTH;
  assign rd_in_range   = rd_addr < DEPTH;
  assign enter_capture = (state_q == ARMED) && fv_rise;
  // Reads and writes are exclusive by state, so the RAM port never collides.
  assign rd_gnt        = rd_req && ((state_q == IDLE) || (state_q == READY));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_req) state_d = ARMED;
      ARMED:   if (fv_rise)     state_d = CAPTURE;
      CAPTURE: if (fv_fall)     state_d = READY;
      READY:   if (capture_req) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      fv_q           <= 1'b0;
      capture_done_q <= 1'b0;
      overflow_q     <= 1'b0;
      pixel_count_q  <= '0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      rd_p1_q        <= 1'b0;
      rd_p2_q        <= 1'b0;
      rd_oor1_q      <= 1'b0;
      rd_oor2_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      fv_q           <= fv;
      capture_done_q <= (state_q == CAPTURE) && fv_fall;
      ram_we_q       <= 1'b0;
      if (wr_accept) begin
        if (wr_in_range) begin
          ram_we_q    <= 1'b1;
          ram_addr_q  <= cam_addr;
          ram_wdata_q <= cam_data;
          if (pixel_count_q != DEPTH) pixel_count_q <= pixel_count_q + ADDR_W'(1);
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (rd_gnt) begin
        ram_addr_q <= rd_addr;
      end
      if (enter_capture) begin
        pixel_count_q <= '0;
        overflow_q    <= 1'b0;
      end
      // Read pipeline: address out, RAM latency, then registered return.
      rd_p1_q    <= rd_gnt;
      rd_oor1_q  <= rd_gnt && !rd_in_range;
      rd_p2_q    <= rd_p1_q;
      rd_oor2_q  <= rd_oor1_q;
      rd_valid_q <= rd_p2_q;
      if (rd_p2_q) rd_data_q <= rd_oor2_q ? '0 : ram_rdata;
    end
  end

  assign state        = state_q;
  assign capture_done = capture_done_q;
  assign overflow_err = overflow_q;
  assign pixel_count  = pixel_count_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_frame_buffer_arbiter;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 160000;
  localparam int MEM_SIZE  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n, capture_req, fv, cam_wr_en, rd_req;
  logic [ADDR_W-1:0] cam_addr, rd_addr;
  logic [DATA_W-1:0] cam_data;
  logic              rd_gnt, rd_valid, ram_we, capture_done, overflow_err;
  logic [DATA_W-1:0] rd_data, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr, pixel_count;
  logic [1:0]        state;

  int nCompared = 0;
  int nMismatched = 0;

  frame_buffer_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .capture_req(capture_req), .fv(fv),
    .cam_wr_en(cam_wr_en), .cam_addr(cam_addr), .cam_data(cam_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .state(state), .capture_done(capture_done),
    .overflow_err(overflow_err), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  logic [DATA_W-1:0] ramMem [MEM_SIZE];
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  // Reference model: mode number, shadow memory and a queue of pending reads.
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;
  rd_t               readQ[$];
  logic [DATA_W-1:0] shadow [MEM_SIZE];
  int                mState, mCount, cycleNo;
  bit                mFvPrev, mDone, mOvf, mWe, mValid;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mWdata, mRdata;

  task automatic modelEdge();
    bit gnt, rise, fall;
    rd_t r;
    cycleNo++;
    if (!reset_n) begin
      mState = 0; mCount = 0; mFvPrev = 0; mDone = 0; mOvf = 0; mWe = 0;
      mValid = 0; mAddr = '0; mWdata = '0; mRdata = '0;
      readQ.delete();
      return;
    end
    gnt  = rd_req && (mState == 0 || mState == 3);
    rise = fv && !mFvPrev;
    fall = !fv && mFvPrev;
    mValid = 0;
    if (readQ.size() > 0 && readQ[0].due == cycleNo) begin
      mValid = 1;
      mRdata = readQ[0].data;
      void'(readQ.pop_front());
    end
    mWe = 0;
    mDone = 0;
    if (mState == 2 && cam_wr_en) begin
      if (int'(cam_addr) < MEM_DEPTH) begin
        mWe = 1; mAddr = cam_addr; mWdata = cam_data;
        shadow[cam_addr] = cam_data;
        if (mCount < MEM_DEPTH) mCount++;
      end else begin
        mOvf = 1;
      end
    end else if (gnt) begin
      mAddr = rd_addr;
      r.due = cycleNo + 2;
      r.data = (int'(rd_addr) < MEM_DEPTH) ? shadow[rd_addr] : '0;
      readQ.push_back(r);
    end
    case (mState)
      0: if (capture_req) mState = 1;
      1: if (rise) begin mState = 2; mCount = 0; mOvf = 0; end
      2: if (fall) begin mState = 3; mDone = 1; end
      3: if (capture_req) mState = 1;
      default: mState = 0;
    endcase
    mFvPrev = fv;
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; capture_req = 0; fv = 0; cam_wr_en = 0; rd_req = 0;
    cam_addr = '0; cam_data = '0; rd_addr = '0;
    step(); step();
    nCompared++; if (state !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    nCompared++; if (ram_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ram_we: got %b want 0", ram_we); end
    nCompared++; if (ram_addr !== '0) begin nMismatched++; $display("[TB] FAIL reset_ram_addr: got %0h want 0", ram_addr); end
    nCompared++; if (ram_wdata !== '0) begin nMismatched++; $display("[TB] FAIL reset_ram_wdata: got %0h want 0", ram_wdata); end
    nCompared++; if (rd_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rd_valid: got %b want 0", rd_valid); end
    nCompared++; if (rd_data !== '0) begin nMismatched++; $display("[TB] FAIL reset_rd_data: got %0h want 0", rd_data); end
    nCompared++; if (capture_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_capture_done: got %b want 0", capture_done); end
    nCompared++; if (overflow_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow_err); end
    nCompared++; if (pixel_count !== '0) begin nMismatched++; $display("[TB] FAIL reset_pixel_count: got %0d want 0", pixel_count); end
    reset_n = 1;
  endtask

  task automatic test_capture_basic();
    int wes = 0, dones = 0;
    capture_req = 1; step(); capture_req = 0;
    nCompared++; if (state !== 2'd1) begin nMismatched++; $display("[TB] FAIL cap_armed: got %0d want 1", state); end
    fv = 1;
    for (int k = 0; k < 10; k++) begin
      cam_wr_en = (k >= 1 && k <= 4);
      cam_addr = ADDR_W'(k - 1);
      cam_data = DATA_W'(8'h11 * k);
      step();
      if (ram_we === 1'b1) wes++;
      nCompared++; if (ram_we !== mWe) begin nMismatched++; $display("[TB] FAIL cap_ram_we: got %b want %b", ram_we, mWe); end
      if (mWe) begin
        nCompared++; if (ram_addr !== mAddr || ram_wdata !== mWdata) begin nMismatched++; $display("[TB] FAIL cap_ram_write: got %0h/%0h want %0h/%0h", ram_addr, ram_wdata, mAddr, mWdata); end
      end
    end
    cam_wr_en = 0; fv = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (capture_done === 1'b1) dones++;
      nCompared++; if (capture_done !== mDone) begin nMismatched++; $display("[TB] FAIL cap_done: got %b want %b", capture_done, mDone); end
    end
    nCompared++; if (wes != 4) begin nMismatched++; $display("[TB] FAIL cap_we_count: got %0d want 4", wes); end
    nCompared++; if (dones != 1) begin nMismatched++; $display("[TB] FAIL cap_done_count: got %0d want 1", dones); end
    nCompared++; if (state !== 2'd3) begin nMismatched++; $display("[TB] FAIL cap_ready: got %0d want 3", state); end
    nCompared++; if (pixel_count !== ADDR_W'(4)) begin nMismatched++; $display("[TB] FAIL cap_pixels: got %0d want 4", pixel_count); end
  endtask

  task automatic test_read_hold();
    int valids = 0;
    rd_addr = ADDR_W'(2);
    for (int k = 0; k < 6; k++) begin
      rd_req = (k < 3);
      #1;
      nCompared++; if (rd_gnt !== (k < 3)) begin nMismatched++; $display("[TB] FAIL hold_gnt: got %b want %b", rd_gnt, (k < 3)); end
      step();
      if (rd_valid === 1'b1) valids++;
      nCompared++; if (rd_valid !== (k >= 2 && k <= 4)) begin nMismatched++; $display("[TB] FAIL hold_valid: got %b want %b", rd_valid, (k >= 2 && k <= 4)); end
      if (k >= 2 && k <= 4) begin
        nCompared++; if (rd_data !== 8'h33) begin nMismatched++; $display("[TB] FAIL hold_data: got %0h want 33", rd_data); end
      end
    end
    nCompared++; if (valids != 3) begin nMismatched++; $display("[TB] FAIL hold_valid_count: got %0d want 3", valids); end
  endtask

  task automatic test_read_during_capture();
    capture_req = 1; step(); capture_req = 0;
    fv = 1; step();
    rd_req = 1; rd_addr = ADDR_W'(1);
    for (int k = 0; k < 4; k++) begin
      #1;
      nCompared++; if (rd_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy_gnt: got %b want 0", rd_gnt); end
      step();
    end
    fv = 0; #1;
    nCompared++; if (rd_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy_gnt_fall: got %b want 0", rd_gnt); end
    step(); #1;
    nCompared++; if (rd_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL ready_gnt: got %b want 1", rd_gnt); end
    step(); rd_req = 0;
    step(); step();
    nCompared++; if (rd_valid !== 1'b1 || rd_data !== 8'h22) begin nMismatched++; $display("[TB] FAIL ready_read: got %b/%0h want 1/22", rd_valid, rd_data); end
  endtask

  task automatic test_overflow();
    capture_req = 1; step(); capture_req = 0;
    fv = 1; step();
    cam_wr_en = 1; cam_addr = ADDR_W'(MEM_DEPTH); cam_data = 8'h5A; step(); cam_wr_en = 0;
    nCompared++; if (ram_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_we: got %b want 0", ram_we); end
    nCompared++; if (overflow_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_set: got %b want 1", overflow_err); end
    fv = 0; step(); step();
    nCompared++; if (overflow_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_ready: got %b want 1", overflow_err); end
    capture_req = 1; step(); capture_req = 0;
    nCompared++; if (overflow_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_armed: got %b want 1", overflow_err); end
    fv = 1; step();
    nCompared++; if (overflow_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_clear: got %b want 0", overflow_err); end
    fv = 0; step(); step();
  endtask

  task automatic test_fv_already_high();
    fv = 1; step();
    capture_req = 1; step(); capture_req = 0;
    for (int k = 0; k < 4; k++) begin
      cam_wr_en = 1; cam_addr = ADDR_W'($urandom_range(100, 199)); cam_data = DATA_W'($urandom);
      step();
      nCompared++; if (state !== 2'd1 || ram_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL fvhigh_wait: got %0d/%b want 1/0", state, ram_we); end
    end
    fv = 0; step();
    nCompared++; if (state !== 2'd1) begin nMismatched++; $display("[TB] FAIL fvhigh_fall: got %0d want 1", state); end
    fv = 1; cam_wr_en = 0; step();
    nCompared++; if (state !== 2'd2) begin nMismatched++; $display("[TB] FAIL fvhigh_rise: got %0d want 2", state); end
    fv = 0; step(); step();
  endtask

  task automatic test_simul_req();
    capture_req = 1; rd_req = 1; rd_addr = ADDR_W'(3); #1;
    nCompared++; if (rd_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL simul_gnt: got %b want 1", rd_gnt); end
    step(); capture_req = 0; rd_req = 0;
    nCompared++; if (state !== 2'd1) begin nMismatched++; $display("[TB] FAIL simul_armed: got %0d want 1", state); end
    step(); step();
    nCompared++; if (rd_valid !== 1'b1 || rd_data !== 8'h44) begin nMismatched++; $display("[TB] FAIL simul_read: got %b/%0h want 1/44", rd_valid, rd_data); end
    fv = 1; step(); fv = 0; step(); step();
  endtask

  task automatic test_back_to_back();
    int valids = 0;
    for (int k = 0; k < 12; k++) begin
      rd_req = (k < 8);
      rd_addr = (k == 5) ? ADDR_W'(MEM_DEPTH + 1) : ADDR_W'($urandom_range(0, 7));
      #1;
      nCompared++; if (rd_gnt !== (k < 8)) begin nMismatched++; $display("[TB] FAIL b2b_gnt: got %b want %b", rd_gnt, (k < 8)); end
      step();
      if (rd_valid === 1'b1) valids++;
      nCompared++; if (rd_valid !== mValid) begin nMismatched++; $display("[TB] FAIL b2b_valid: got %b want %b", rd_valid, mValid); end
      if (mValid) begin
        nCompared++; if (rd_data !== mRdata) begin nMismatched++; $display("[TB] FAIL b2b_data: got %0h want %0h", rd_data, mRdata); end
      end
    end
    nCompared++; if (valids != 8) begin nMismatched++; $display("[TB] FAIL b2b_count: got %0d want 8", valids); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      capture_req = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 5) == 0) fv = ~fv;
      cam_wr_en = 1'($urandom_range(0, 1));
      cam_addr = ($urandom_range(0, 9) == 0) ? ADDR_W'(MEM_DEPTH - 1 + int'($urandom_range(0, 2)))
                                             : ADDR_W'($urandom_range(0, 63));
      cam_data = DATA_W'($urandom);
      rd_req = ($urandom_range(0, 2) == 0);
      rd_addr = ($urandom_range(0, 9) == 0) ? ADDR_W'(MEM_DEPTH - 1 + int'($urandom_range(0, 2)))
                                            : ADDR_W'($urandom_range(0, 63));
      #1;
      nCompared++; if (rd_gnt !== (rd_req && (mState == 0 || mState == 3))) begin nMismatched++; $display("[TB] FAIL rnd_gnt: got %b state %0d", rd_gnt, mState); end
      step();
      nCompared++; if (state !== 2'(mState)) begin nMismatched++; $display("[TB] FAIL rnd_state: got %0d want %0d", state, mState); end
      nCompared++; if (ram_we !== mWe || ram_addr !== mAddr) begin nMismatched++; $display("[TB] FAIL rnd_ram: got %b/%0h want %b/%0h", ram_we, ram_addr, mWe, mAddr); end
      if (mWe) begin
        nCompared++; if (ram_wdata !== mWdata) begin nMismatched++; $display("[TB] FAIL rnd_wdata: got %0h want %0h", ram_wdata, mWdata); end
      end
      nCompared++; if (rd_valid !== mValid) begin nMismatched++; $display("[TB] FAIL rnd_valid: got %b want %b", rd_valid, mValid); end
      if (mValid) begin
        nCompared++; if (rd_data !== mRdata) begin nMismatched++; $display("[TB] FAIL rnd_data: got %0h want %0h", rd_data, mRdata); end
      end
      nCompared++; if (capture_done !== mDone || overflow_err !== mOvf) begin nMismatched++; $display("[TB] FAIL rnd_status: got %b/%b want %b/%b", capture_done, overflow_err, mDone, mOvf); end
      nCompared++; if (pixel_count !== ADDR_W'(mCount)) begin nMismatched++; $display("[TB] FAIL rnd_pixels: got %0d want %0d", pixel_count, mCount); end
    end
    reset_n = 1; capture_req = 0; cam_wr_en = 0; rd_req = 0;
  endtask

  task automatic test_reset_mid_capture();
    reset_n = 0; fv = 0; step(); reset_n = 1;
    capture_req = 1; step(); capture_req = 0;
    fv = 1; step();
    cam_wr_en = 1; cam_addr = ADDR_W'(10); cam_data = 8'h77; step();
    nCompared++; if (state !== 2'd2 || pixel_count !== ADDR_W'(1)) begin nMismatched++; $display("[TB] FAIL midrst_pre: got %0d/%0d want 2/1", state, pixel_count); end
    cam_addr = ADDR_W'(11); reset_n = 0; fv = 0; step();
    nCompared++; if (state !== 2'd0) begin nMismatched++; $display("[TB] FAIL midrst_state: got %0d want 0", state); end
    nCompared++; if (ram_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_we: got %b want 0", ram_we); end
    nCompared++; if (pixel_count !== '0) begin nMismatched++; $display("[TB] FAIL midrst_pixels: got %0d want 0", pixel_count); end
    nCompared++; if (capture_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_done: got %b want 0", capture_done); end
    reset_n = 1; cam_wr_en = 0; step();
    nCompared++; if (capture_done !== 1'b0 || state !== 2'd0) begin nMismatched++; $display("[TB] FAIL midrst_after: got %b/%0d want 0/0", capture_done, state); end
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) begin
      ramMem[i] = '0;
      shadow[i] = '0;
    end
    cycleNo = 0;
    test_reset();
    test_capture_basic();
    test_read_hold();
    test_read_during_capture();
    test_overflow();
    test_fv_already_high();
    test_simul_req();
    test_back_to_back();
    test_random();
    test_reset_mid_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
